// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcode enum and ALU evaluation helper for the datapath and its control unit.
package datapath_pkg;
  localparam int DATA_W   = 16;
  localparam int RF_AW    = 4;
  localparam int DM_AW    = 8;
  localparam int RF_DEPTH = 1 << RF_AW;
  localparam int DM_DEPTH = 1 << DM_AW;

  typedef enum logic [2:0] {
    ALU_ZERO   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_PASS_A = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_OR     = 3'd5,
    ALU_AND    = 3'd6,
    ALU_INC    = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              carry;
  } alu_res_t;

  // Ops are evaluated 17 bits wide; bit 16 is the carry, or the borrow (a<b) for SUB.
  function automatic alu_res_t alu_eval(alu_op_t op, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    alu_res_t        r;
    sum = '0;
    case (op)
      ALU_ADD:    sum = {1'b0, a} + {1'b0, b};
      ALU_SUB:    sum = {1'b0, a} - {1'b0, b};
      ALU_PASS_A: sum = {1'b0, a};
      ALU_XOR:    sum = {1'b0, a ^ b};
      ALU_OR:     sum = {1'b0, a | b};
      ALU_AND:    sum = {1'b0, a & b};
      ALU_INC:    sum = {1'b0, a} + {{DATA_W{1'b0}}, 1'b1};
      default:    sum = '0;
    endcase
    r.res   = sum[DATA_W-1:0];
    r.carry = sum[DATA_W];
    return r;
  endfunction
endpackage

// File: rtl/register_file.sv
// 16 x 16 register file: two asynchronous read ports, one clocked write port.
module register_file
  import datapath_pkg::*;
(
  input  logic              Clk,
  input  logic              ResetN,
  input  logic              we,
  input  logic [RF_AW-1:0]  w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [RF_AW-1:0]  ra_addr,
  input  logic [RF_AW-1:0]  rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);
  logic [RF_DEPTH-1:0][DATA_W-1:0] regs;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)  regs         <= '0;
    else if (we)  regs[w_addr] <= w_data;
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];
endmodule

// File: rtl/datapath.sv
// Datapath: register file, ALU, write-back mux, 256 x 16 data memory with registered read, Z/C flags.
module datapath
  import datapath_pkg::*;
(
  input  logic              Clk,
  input  logic              ResetN,
  input  logic [DM_AW-1:0]  D_Addr,
  input  logic              D_Wr,
  input  logic              RF_s,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_W_addr,
  input  logic [RF_AW-1:0]  RF_Ra_addr,
  input  logic [RF_AW-1:0]  RF_Rb_addr,
  input  logic [2:0]        ALU_s0,
  output logic [DATA_W-1:0] Ra_data,
  output logic [DATA_W-1:0] Rb_data,
  output logic [DATA_W-1:0] ALU_Out,
  output logic              Z_flag,
  output logic              C_flag
);
  logic [DATA_W-1:0] mem [DM_DEPTH];
  logic [DATA_W-1:0] mem_q;
  logic [DATA_W-1:0] wb_data;
  logic              mem_we;
  alu_res_t          alu;

  assign alu     = alu_eval(alu_op_t'(ALU_s0), Ra_data, Rb_data);
  assign ALU_Out = alu.res;
  assign wb_data = RF_s ? mem_q : ALU_Out;

  register_file u_rf (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .we      (RF_W_en),
    .w_addr  (RF_W_addr),
    .w_data  (wb_data),
    .ra_addr (RF_Ra_addr),
    .rb_addr (RF_Rb_addr),
    .ra_data (Ra_data),
    .rb_data (Rb_data)
  );

  // Memory array is never reset; writes are simply blocked while reset is held.
  assign mem_we = D_Wr && ResetN;

  always_ff @(posedge Clk) begin
    if (mem_we) mem[D_Addr] <= Ra_data;
  end

  // Read-before-write: a same-address write in this cycle is seen one edge later.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) mem_q <= '0;
    else         mem_q <= mem[D_Addr];
  end

  // Flags track only ALU results that are written back.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Z_flag <= 1'b0;
      C_flag <= 1'b0;
    end else if (RF_W_en && !RF_s) begin
      Z_flag <= (alu.res == '0);
      C_flag <= alu.carry;
    end
  end
endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL provide: Clk  input  1  rising-edge clock for all state.
REQ-002 SHALL provide: ResetN  input  1  reset; one clock, reset asynchronous and active-low.
REQ-003 SHALL provide: D_Addr  input  8  data-memory address.
REQ-004 SHALL provide: D_Wr  input  1  data-memory write enable.
REQ-005 SHALL provide: RF_s  input  1  write-back mux select (1 = memory read data, 0 = ALU result).
REQ-006 SHALL provide: RF_W_en  input  1  register-file write enable.
REQ-007 SHALL provide: RF_W_addr, RF_Ra_addr, RF_Rb_addr  input  4 each  register write / A-read / B-read addresses.
REQ-008 SHALL provide: ALU_s0  input  3  ALU function select.
REQ-009 SHALL provide: Ra_data, Rb_data  output  16 each  register-file read ports A and B.
REQ-010 SHALL provide: ALU_Out  output  16  combinational ALU result.
REQ-011 SHALL provide: Z_flag, C_flag  output  1 each  registered zero and carry/borrow status.

Function
REQ-012 Register file SHALL hold 16 x 16-bit registers, with asynchronous reads and a write at the rising edge when RF_W_en=1.
REQ-013 Write-back data SHALL be RF_s ? MemQ : ALU_Out, where MemQ is the registered memory read data.
REQ-014 Data memory SHALL hold 256 x 16 bits; each rising edge SHALL set MemQ <= mem[D_Addr]; read latency is exactly 1 cycle (a load needs 2 states: address cycle, then write-back cycle).
REQ-015 When D_Wr=1, each rising edge SHALL write mem[D_Addr] <= Ra_data.
REQ-016 On a memory read-during-write to the same address, MemQ SHALL return the old contents.
REQ-017 ALU_s0 encoding SHALL be: 0 = 0x0000, 1 = A+B, 2 = A-B, 3 = pass A, 4 = A^B, 5 = A|B, 6 = A&B, 7 = A+1; A = Ra_data, B = Rb_data.
REQ-018 ALU arithmetic SHALL wrap modulo 2^16; carry = bit 16 of the add; borrow = (A<B) for subtract; carry = 0 for logic ops.
REQ-019 When RF_W_en=1 and RF_s=0, each rising edge SHALL update Z_flag <= (ALU_Out==0) and C_flag <= carry/borrow; otherwise both flags SHALL hold.
REQ-020 When a register is read and written at the same address in the same cycle, the read port SHALL show the old value before the edge and the new value after it.
REQ-021 Simultaneous RF_W_en and D_Wr SHALL both take effect; memory SHALL receive the pre-edge Ra_data.
REQ-022 Address 0xFF SHALL be a normal location with no wrap-around side effects; all 16 registers, including R0, SHALL be writable.

Reset
REQ-023 ResetN=0 SHALL immediately clear all 16 registers, MemQ, Z_flag and C_flag to 0, regardless of Clk.
REQ-024 Data memory contents SHALL NOT be affected by reset.
REQ-025 While ResetN=0, all writes (register file, memory, flags) SHALL be suppressed.
REQ-026 Reset asserted mid-load SHALL discard the pending MemQ value.
REQ-027 The first capture after reset SHALL be on the first rising edge with ResetN=1.

Structure
REQ-028 A shared package SHALL define the alu_op_t enum (the 8 codes above) and the width constants DATA_W=16, RF_AW=4, DM_AW=8; the control unit SHALL use the same package.
REQ-029 The register file SHALL be a single sub-module named register_file; the ALU, write-back mux, data memory and flags SHALL be implemented inline in datapath.

Verification
REQ-030 Reset: pulse ResetN low between edges -> Ra_data, Rb_data = 0 for every address, Z_flag = C_flag = 0 with no clock edge.
REQ-031 Add: R1=0x7FFF, R2=0x0001, ALU_s0=1, RF_W_addr=3, RF_W_en=1 -> R3=0x8000, Z=0, C=0; then R1=0xFFFF + R2=0x0001 -> 0x0000, Z=1, C=1.
REQ-032 Sub: R4=0x0005, R5=0x0007, ALU_s0=2 -> 0xFFFE, C=1 (borrow), Z=0.
REQ-033 Store/load: Ra=R3 (0x8000), D_Addr=0x2A, D_Wr=1 -> mem[0x2A]=0x8000; then D_Addr=0x2A for 1 cycle followed by RF_s=1, RF_W_en=1, RF_W_addr=6 -> R6=0x8000, flags unchanged.
REQ-034 Read-during-write: D_Wr=1 at 0x10 with old value 0x1111 and new value 0x2222 -> MemQ=0x1111 after that edge and 0x2222 one edge later.
REQ-035 Reset mid-load: ResetN low after the address cycle -> MemQ=0, the target register stays 0, and memory contents are retained.
